clk_div_prog: RTL and testbench

Runtime-programmable clock divider and clock-enable generator. It extends the fixed-divisor divider with a configurable period and high time, a glitch-free update path that applies new settings only at period boundaries, a run enable, and a one-cycle `tick` strobe for driving enable-based logic in the display pipeline. It sits between the system clock and the pixel/line timing blocks, and is configured by the control logic through a valid/ready port.

---
 rtl/clk_div_prog.sv | 154 +++++++++++++++
 tb/tb_clk_div_prog.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Purpose  : Runtime-programmable clock divider and clock-enable generator.
//            Produces a registered divided clock (clk_out) and a one-cycle
//            tick strobe on the first cycle of every period. New period/high
//            settings are accepted into a shadow register through a
//            valid/ready port and applied only at a period boundary (or on
//            the next edge while idle), so clk_out never glitches.
// Ports    : clk_in      - single clock, all logic on its rising edge
//            rst         - synchronous active-high reset
//            enable      - 1 = run, 0 = idle (aborts the current period)
//            cfg_valid   - configuration request
//            cfg_ready   - shadow register is free
//            cfg_div     - requested period in clk_in cycles (0 stored as 1)
//            cfg_high    - requested clk_out high time in cycles
//            clk_out     - divided clock, registered
//            tick        - one-cycle pulse on cnt == 0, registered
//            cfg_pending - shadow holds a setting not yet applied
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_DEF_HIGH = CNT_W'(DEFAULT_HIGH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_a_q, div_a_d;
  logic [CNT_W-1:0]   high_a_q, high_a_d;
  logic [CNT_W-1:0]   div_s_q, div_s_d;
  logic [CNT_W-1:0]   high_s_q, high_s_d;
  logic               pending_q, pending_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;

  logic               w_accept;
  logic               w_wrap;

  // The shadow can only be written while empty, so accept and apply never
  // collide on the same edge.
  assign w_accept = cfg_valid & ~pending_q;
  // div_a is never 0, so div_a-1 cannot underflow; >= keeps the counter
  // self-correcting should it ever sit above the last count.
  assign w_wrap   = (cnt_q >= (div_a_q - C_ONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_a_d   = div_a_q;
    high_a_d  = high_a_q;
    div_s_d   = div_s_q;
    high_s_d  = high_s_q;
    pending_d = pending_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Nothing is being generated, so a pending setting is safe to apply.
        if (pending_q) begin
          div_a_d   = div_s_q;
          high_a_d  = high_s_q;
          pending_d = 1'b0;
        end
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          // Abort the period; a pending setting waits for the idle edge.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (w_wrap) begin
          cnt_d = '0;
          if (pending_q) begin
            div_a_d   = div_s_q;
            high_a_d  = high_s_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (w_accept) begin
      div_s_d   = (cfg_div == '0) ? C_ONE : cfg_div;
      high_s_d  = cfg_high;
      pending_d = 1'b1;
    end

    // Outputs are registered from the next-cycle count and settings, so they
    // line up with the cnt value that is visible after the edge.
    clk_out_d = (state_d == ST_RUN) && (cnt_d < high_a_d);
    tick_d    = (state_d == ST_RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_a_q   <= C_DEF_DIV;
      high_a_q  <= C_DEF_HIGH;
      div_s_q   <= C_DEF_DIV;
      high_s_q  <= C_DEF_HIGH;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_a_q   <= div_a_d;
      high_a_q  <= high_a_d;
      div_s_q   <= div_s_d;
      high_s_q  <= high_s_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign cfg_pending = pending_q;
  assign cfg_ready   = ~pending_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_prog
// Purpose  : Self-checking bench for clk_div_prog. Each scenario task queues
//            per-cycle stimulus together with the hand-derived expected
//            {clk_out, tick, cfg_ready, cfg_pending} seen after that edge,
//            then replays the stimulus and checks each popped expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             cfg_pending;

  clk_div_prog #(
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (2),
    .DEFAULT_HIGH (1)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic             r;
    logic             en;
    logic             v;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] h;
  } stim_t;

  stim_t      stim_q[$];
  logic [3:0] exp_q[$];   // {clk_out, tick, cfg_ready, cfg_pending}
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic add(input logic r, input logic en, input logic v,
                     input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] h,
                     input logic [3:0] e);
    stim_t s;
    s.r = r; s.en = en; s.v = v; s.d = d; s.h = h;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    rst       = s.r;
    enable    = s.en;
    cfg_valid = s.v;
    cfg_div   = s.d;
    cfg_high  = s.h;
    @(posedge clk_in);
    #1;
  endtask

  // Reset wins even with enable and cfg_valid asserted.
  task automatic test_reset();
    logic [3:0] e, got;
    int cyc = 0;
    add(1, 1, 1, 3, 3, 4'b0010);
    add(1, 0, 0, 0, 0, 4'b0010);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_default_run();
    logic [3:0] e, got;
    int cyc = 0;
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 0, (i % 2 == 0) ? 4'b1110 : 4'b0010);
    add(0, 0, 0, 0, 0, 4'b0010);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL default_run cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  // div4/high2 running, div5/high3 sent while cnt=1.
  task automatic test_apply_boundary();
    logic [3:0] e, got;
    int cyc = 0;
    add(0, 0, 1, 4, 2, 4'b0001);   // accepted while idle
    add(0, 0, 0, 0, 0, 4'b0010);   // applied on the next idle edge
    add(0, 1, 0, 0, 0, 4'b1110);   // cnt0
    add(0, 1, 0, 0, 0, 4'b1010);   // cnt1
    add(0, 1, 1, 5, 3, 4'b0001);   // cnt2, accepted
    add(0, 1, 0, 0, 0, 4'b0001);   // cnt3
    add(0, 1, 0, 0, 0, 4'b1110);   // wrap: new settings, pending drops
    add(0, 1, 0, 0, 0, 4'b1010);
    add(0, 1, 0, 0, 0, 4'b1010);
    add(0, 1, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b1110);   // five-cycle period
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL apply_boundary cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  // Running div5/high3 at cnt0. A = div3/high1, B = div2/high2 held.
  task automatic test_back_to_back();
    logic [3:0] e, got;
    int cyc = 0;
    add(0, 1, 1, 3, 1, 4'b1001);   // cnt1, A accepted
    add(0, 1, 1, 2, 2, 4'b1001);   // cnt2, B held
    add(0, 1, 1, 2, 2, 4'b0001);   // cnt3
    add(0, 1, 1, 2, 2, 4'b0001);   // cnt4
    add(0, 1, 1, 2, 2, 4'b1110);   // wrap: A applied, B not yet taken
    add(0, 1, 1, 2, 2, 4'b0001);   // B accepted, cnt1 of div3/high1
    add(0, 1, 0, 0, 0, 4'b0001);   // cnt2
    add(0, 1, 0, 0, 0, 4'b1110);   // wrap: B applied
    add(0, 1, 0, 0, 0, 4'b1010);   // high >= div: clk stays 1
    add(0, 1, 0, 0, 0, 4'b1110);
    add(0, 0, 0, 0, 0, 4'b0010);   // back to idle
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_boundary();
    logic [3:0] e, got;
    int cyc = 0;
    int cd[4];
    int ch[4];
    int tp[4];
    logic cc[4];
    cd = '{4, 4, 0, 1};
    ch = '{0, 7, 0, 1};
    tp = '{4, 4, 1, 1};       // expected tick spacing
    cc = '{1'b0, 1'b1, 1'b0, 1'b1}; // expected constant clk_out
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 1, CNT_W'(cd[k]), CNT_W'(ch[k]), 4'b0001);
      add(0, 0, 0, 0, 0, 4'b0010);
      for (int i = 0; i < 8; i++)
        add(0, 1, 0, 0, 0, {cc[k], (i % tp[k] == 0), 1'b1, 1'b0});
      add(0, 0, 0, 0, 0, 4'b0010);
    end
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL boundary cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] e, got;
    int cyc = 0;
    add(0, 0, 1, 6, 3, 4'b0001);
    add(0, 0, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b1110);   // cnt0
    add(0, 1, 0, 0, 0, 4'b1010);   // cnt1
    add(0, 1, 0, 0, 0, 4'b1010);   // cnt2
    add(0, 0, 0, 0, 0, 4'b0010);   // dropped
    add(0, 0, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b1110);   // restart at cnt0
    add(0, 1, 0, 0, 0, 4'b1010);
    add(0, 1, 0, 0, 0, 4'b1010);
    add(0, 1, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b0010);
    add(0, 1, 0, 0, 0, 4'b1110);   // full six-cycle period
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL enable_drop cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  // Running div6/high3 at cnt0; div3/high0 goes pending, then reset.
  task automatic test_reset_mid();
    logic [3:0] e, got;
    int cyc = 0;
    add(0, 1, 1, 3, 0, 4'b1001);
    add(1, 1, 0, 0, 0, 4'b0010);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, (i % 2 == 0) ? 4'b1110 : 4'b0010);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  // Defaults running at cnt1: accept on a wrap edge, then drop enable on
  // the following wrap with the setting still pending.
  task automatic test_drop_at_wrap();
    logic [3:0] e, got;
    int cyc = 0;
    add(0, 1, 1, 3, 3, 4'b1101);   // accepted on wrap: old div2 still runs
    add(0, 1, 0, 0, 0, 4'b0001);   // cnt1 of div2
    add(0, 0, 0, 0, 0, 4'b0001);   // drop on wrap: idle, still pending
    add(0, 0, 0, 0, 0, 4'b0010);   // applied while idle
    add(0, 1, 0, 0, 0, 4'b1110);   // div3/high3
    add(0, 1, 0, 0, 0, 4'b1010);
    add(0, 1, 0, 0, 0, 4'b1010);
    add(0, 1, 0, 0, 0, 4'b1110);
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = {clk_out, tick, cfg_ready, cfg_pending};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL drop_at_wrap cyc %0d: clk/tick/rdy/pend got %b want %b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_default_run();
    test_apply_boundary();
    test_back_to_back();
    test_boundary();
    test_enable_drop();
    test_reset_mid();
    test_drop_at_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
